// File: rtl/alu_pipe_if.sv
// Request/result handshake bundle between an ALU client and alu_pipe.
interface alu_pipe_if #(
    parameter int WIDTH    = 15,
    parameter int OP_WIDTH = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [OP_WIDTH-1:0] alu_op;
    logic [WIDTH-1:0]    op1;
    logic [WIDTH-1:0]    op2;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH:0]      out;
    logic [3:0]          flags;
    logic                err;

    modport slave (
        input  in_valid, alu_op, op1, op2, out_ready,
        output in_ready, out_valid, out, flags, err
    );

    modport master (
        output in_valid, alu_op, op1, op2, out_ready,
        input  in_ready, out_valid, out, flags, err
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage ALU: operands captured on accept, result registered one edge later;
// MUL runs as a WIDTH-step shift-add sequence that blocks new requests.
module alu_pipe #(
    parameter int WIDTH    = 15,
    parameter int OP_WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]    W_MOD  = WIDTH'(WIDTH);
    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(11);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                 state_q, state_d;
    logic                   s1_vld_q;
    logic [OP_WIDTH-1:0]    op_q;
    logic [WIDTH-1:0]       a_q, b_q;
    logic [2*WIDTH-1:0]     mcand_q, acc_q, acc_d;
    logic [WIDTH-1:0]       mplier_q;
    logic [CW-1:0]          cnt_q;
    logic                   out_valid_q, err_q;
    logic [WIDTH:0]         out_q;
    logic [3:0]             flags_q;

    logic                   out_free, in_ready, accept, mul_start;
    logic                   s1_fire, mul_last, mul_step, mul_done;
    logic [WIDTH:0]         alu_res;
    logic                   alu_ovf, alu_err;
    logic [WIDTH-1:0]       shamt, sra_res;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_start) state_d = S_MUL;
            S_MUL:   if (mul_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. The last MUL step waits for a free result register, since a
    // single-cycle op accepted just before the MUL may still be undrained.
    always_comb begin
        out_free  = !out_valid_q || bus.out_ready;
        in_ready  = (state_q == S_IDLE) && out_free;
        accept    = bus.in_valid && in_ready;
        mul_start = accept && (bus.alu_op == OP_MUL);
        s1_fire   = s1_vld_q && out_free;
        mul_last  = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));
        mul_step  = (state_q == S_MUL) && (!mul_last || out_free);
        mul_done  = mul_last && out_free;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (accept) begin
            s1_vld_q <= (bus.alu_op != OP_MUL);
            op_q     <= bus.alu_op;
            a_q      <= bus.op1;
            b_q      <= bus.op2;
        end else if (s1_fire) begin
            s1_vld_q <= 1'b0;
        end
    end

    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (mul_start) begin
            mcand_q  <= {{WIDTH{1'b0}}, bus.op1};
            mplier_q <= bus.op2;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (mul_step) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    assign shamt   = b_q % W_MOD;
    assign sra_res = WIDTH'($signed(a_q) >>> shamt);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = {1'b0, a_q} + {1'b0, b_q};
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = {1'b0, a_q} - {1'b0, b_q};
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = {1'b0, a_q & b_q};
            OP_OR:   alu_res = {1'b0, a_q | b_q};
            OP_XOR:  alu_res = {1'b0, a_q ^ b_q};
            OP_SLL:  alu_res = {1'b0, a_q << shamt};
            OP_SRL:  alu_res = {1'b0, a_q >> shamt};
            OP_SRA:  alu_res = {1'b0, sra_res};
            OP_SLT:  alu_res = {{WIDTH{1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SLTU: alu_res = {{WIDTH{1'b0}}, a_q < b_q};
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else if (s1_fire) begin
            out_valid_q <= 1'b1;
            out_q       <= alu_res;
            flags_q     <= {alu_ovf, alu_res[WIDTH-1], alu_res[WIDTH], alu_res[WIDTH-1:0] == '0};
            err_q       <= alu_err;
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            out_q       <= {1'b0, acc_d[WIDTH-1:0]};
            flags_q     <= {|acc_d[2*WIDTH-1:WIDTH], acc_d[WIDTH-1], 1'b0, acc_d[WIDTH-1:0] == '0};
            err_q       <= 1'b0;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
    localparam int W   = 15;
    localparam int OPW = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_pipe_if #(.WIDTH(W), .OP_WIDTH(OPW)) bus();
    alu_pipe #(.WIDTH(W), .OP_WIDTH(OPW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W:0] out;
        logic [3:0] flags;
        logic       err;
    } exp_t;

    function automatic exp_t model(input int op, input int a, input int b);
        exp_t   e;
        longint m, sa, sb, r, s;
        bit     ov;
        m  = longint'(1) << W;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        ov = 1'b0;
        e.err = 1'b0;
        case (op)
            1:  begin r = a + b; s = sa + sb; ov = (s < -m / 2) || (s >= m / 2); end
            2:  begin r = (a - b) & (2 * m - 1); s = sa - sb; ov = (s < -m / 2) || (s >= m / 2); end
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = (longint'(a) << (b % W)) % m;
            7:  r = a >> (b % W);
            8:  r = (sa >>> (b % W)) & (m - 1);
            9:  r = (sa < sb) ? 1 : 0;
            10: r = (a < b) ? 1 : 0;
            11: begin s = longint'(a) * b; r = s % m; ov = (s >= m); end
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.out   = r[W:0];
        e.flags = {ov, r[W-1], r[W], (r % m) == 0};
        return e;
    endfunction

    // Presents one request at a negedge, returns edges from accept to out_valid.
    task automatic send(input int op, input int a, input int b, output int lat);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.alu_op   = OPW'(op);
        bus.op1      = W'(a);
        bus.op2      = W'(b);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.alu_op   = OPW'($urandom);
        bus.op1      = W'($urandom);
        bus.op2      = W'($urandom);
        @(negedge clk);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.flags !== 4'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b out=%h fl=%b err=%b want 0/0/0/0",
                     bus.out_valid, bus.out, bus.flags, bus.err);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        int lat;
        send(1, 'h7FFF, 'h0001, lat);
        checks++;
        if (lat !== 1 || bus.out !== 16'h8000 || bus.flags !== 4'b0011 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL add_carry: got lat=%0d out=%h fl=%b err=%b want 1/8000/0011/0",
                     lat, bus.out, bus.flags, bus.err);
        end
        send(2, 5, 7, lat);
        checks++;
        if (lat !== 1 || bus.out !== 16'hFFFE || bus.flags !== 4'b0110) begin
            failures++;
            $display("FAIL sub_borrow: got lat=%0d out=%h fl=%b want 1/fffe/0110", lat, bus.out, bus.flags);
        end
        send(9, 5, 7, lat);
        checks++;
        if (bus.out !== 16'h0001 || bus.flags !== 4'b0000) begin
            failures++;
            $display("FAIL slt: got out=%h fl=%b want 0001/0000", bus.out, bus.flags);
        end
        send(15, 'h1234, 'h0042, lat);
        checks++;
        if (lat !== 1 || bus.out !== '0 || bus.flags !== 4'b0001 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_op: got lat=%0d out=%h fl=%b err=%b want 1/0/0001/1",
                     lat, bus.out, bus.flags, bus.err);
        end
        send(3, 'h7F0F, 'h00FF, lat);
        checks++;
        if (bus.err !== 1'b0 || bus.out !== 16'h000F) begin
            failures++;
            $display("FAIL err_clear: got err=%b out=%h want 0/000f", bus.err, bus.out);
        end
    endtask

    task automatic test_mul();
        int lat, low;
        bus.in_valid = 1'b1;
        bus.alu_op   = OPW'(11);
        bus.op1      = W'(3);
        bus.op2      = W'(5);
        @(posedge clk);
        #1;
        // Keep a live request on the bus while busy; it must be ignored.
        bus.alu_op = OPW'(1);
        bus.op1    = W'($urandom);
        bus.op2    = W'($urandom);
        lat = 0;
        low = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            if (!bus.in_ready) low++;
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (lat !== W || low !== W) begin
            failures++;
            $display("FAIL mul_latency: got lat=%0d ready_low=%0d want %0d/%0d", lat, low, W, W);
        end
        checks++;
        if (bus.out !== 16'h000F || bus.flags !== 4'b0000 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL mul_3x5: got out=%h fl=%b err=%b want 000f/0000/0", bus.out, bus.flags, bus.err);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mul_busy_ignored: got out_valid=%b want 0", bus.out_valid);
        end
        send(11, 'h0100, 'h0080, lat);
        checks++;
        if (lat !== W || bus.out !== '0 || bus.flags !== 4'b1001) begin
            failures++;
            $display("FAIL mul_ovf: got lat=%0d out=%h fl=%b want %0d/0/1001", lat, bus.out, bus.flags, W);
        end
    endtask

    task automatic test_back_to_back();
        int   lat, a1, b1, a2, b2;
        exp_t e1, e2;
        a1 = $urandom_range(0, (1 << W) - 1);
        b1 = $urandom_range(0, (1 << W) - 1);
        a2 = $urandom_range(0, (1 << W) - 1);
        b2 = $urandom_range(0, (1 << W) - 1);
        e1 = model(1, a1, b1);
        e2 = model(1, a2, b2);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(1, a1, b1, lat);
        checks++;
        if (lat !== 1 || bus.out !== e1.out || bus.flags !== e1.flags) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d out=%h fl=%b want 1/%h/%b", lat, bus.out, bus.flags, e1.out, e1.flags);
        end
        bus.in_valid = 1'b1;
        bus.alu_op   = OPW'(1);
        bus.op1      = W'(a2);
        bus.op2      = W'(b2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out !== e1.out || bus.flags !== e1.flags) begin
                failures++;
                $display("FAIL b2b_hold: got rdy=%b v=%b out=%h want 0/1/%h", bus.in_ready, bus.out_valid, bus.out, e1.out);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_rise: got %b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_drained: got out_valid=%b want 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== e2.out || bus.flags !== e2.flags) begin
            failures++;
            $display("FAIL b2b_second: got v=%b out=%h fl=%b want 1/%h/%b", bus.out_valid, bus.out, bus.flags, e2.out, e2.flags);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_dup: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        int   op, a, b, lat;
        exp_t e;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 15);
            a  = $urandom_range(0, (1 << W) - 1);
            b  = (i % 4 == 0) ? $urandom_range(0, 40) : $urandom_range(0, (1 << W) - 1);
            e  = model(op, a, b);
            send(op, a, b, lat);
            checks++;
            if (lat !== ((op == 11) ? W : 1)) begin
                failures++;
                $display("FAIL rand_latency op=%0d: got %0d want %0d", op, lat, (op == 11) ? W : 1);
            end
            checks++;
            if (bus.out !== e.out || bus.flags !== e.flags || bus.err !== e.err) begin
                failures++;
                $display("FAIL rand_result op=%0d a=%h b=%h: got out=%h fl=%b err=%b want %h/%b/%b",
                         op, a, b, bus.out, bus.flags, bus.err, e.out, e.flags, e.err);
            end
        end
    endtask

    task automatic test_mul_reset();
        int lat, seen;
        send(1, 1, 2, lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = OPW'(11);
        bus.op1      = W'(123);
        bus.op2      = W'(45);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.flags !== 4'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL mul_reset_outputs: got v=%b out=%h fl=%b err=%b want 0/0/0/0",
                     bus.out_valid, bus.out, bus.flags, bus.err);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_reset_ready: got %b want 1", bus.in_ready);
        end
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mul_reset_stale: got %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_mul();
        test_back_to_back();
        test_random();
        test_mul_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
